adder_resp_checker: RTL

Synthesizable response checker for the 1-bit full-adder test interface. It sits on the adder-under-test's output side. It takes each applied operand vector {a, b, ci} with a valid strobe, waits SETTLE clocks, samples the adder's sum and co, and compares them against the golden full-adder result. It keeps pass/fail counters, a sticky first-failure capture, operand-space coverage, and an overall verdict state, so the same check can run on silicon or FPGA without a simulator $monitor.

---
 rtl/adder_resp_checker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/adder_resp_checker.sv
// Response checker for a 1-bit full adder under test: delays each applied vector
// SETTLE clocks, compares the live sum/co against the golden result, and keeps verdict state.
module adder_resp_checker #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic             ci,
  input  logic             sum,
  input  logic             co,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [4:0]       first_err_vec,
  output logic [7:0]       cov_map,
  output logic             cov_full,
  output logic [1:0]       status
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PASSING = 2'b01,
    ST_FAILED  = 2'b10
  } state_t;

  // Each stage holds {valid, a, b, ci}; operands are zeroed when not valid.
  genvar gi;
  for (gi = 0; gi < SETTLE; gi++) begin : g_stage
    logic [3:0] stage_reg;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         stage_reg <= 4'b0;
        else if (clr)       stage_reg <= 4'b0;
        else if (vec_valid) stage_reg <= {1'b1, a, b, ci};
        else                stage_reg <= 4'b0;
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   stage_reg <= 4'b0;
        else if (clr) stage_reg <= 4'b0;
        else          stage_reg <= g_stage[gi-1].stage_reg;
      end
    end
  end

  logic [3:0] pipe_out;
  logic       cmp_valid;
  logic [2:0] cmp_vec;
  logic       exp_sum;
  logic       exp_co;
  logic       mismatch;
  logic [7:0] cov_map_next;

  assign pipe_out     = g_stage[SETTLE-1].stage_reg;
  assign cmp_valid    = pipe_out[3];
  assign cmp_vec      = pipe_out[2:0];
  assign exp_sum      = cmp_vec[2] ^ cmp_vec[1] ^ cmp_vec[0];
  assign exp_co       = (cmp_vec[2] & cmp_vec[1]) | (cmp_vec[2] & cmp_vec[0]) | (cmp_vec[1] & cmp_vec[0]);
  assign mismatch     = (sum != exp_sum) || (co != exp_co);

  logic [CNT_W-1:0] checked_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic             first_err_valid_reg;
  logic [4:0]       first_err_vec_reg;
  logic [7:0]       cov_map_reg;
  logic             cov_full_reg;
  state_t           state_reg;

  assign cov_map_next = cov_map_reg | (8'b1 << cmp_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checked_cnt_reg     <= '0;
      err_cnt_reg         <= '0;
      first_err_valid_reg <= 1'b0;
      first_err_vec_reg   <= 5'b0;
      cov_map_reg         <= 8'b0;
      cov_full_reg        <= 1'b0;
      state_reg           <= ST_IDLE;
    end else if (clr) begin
      checked_cnt_reg     <= '0;
      err_cnt_reg         <= '0;
      first_err_valid_reg <= 1'b0;
      first_err_vec_reg   <= 5'b0;
      cov_map_reg         <= 8'b0;
      cov_full_reg        <= 1'b0;
      state_reg           <= ST_IDLE;
    end else if (cmp_valid) begin
      // Counters saturate at all-ones rather than wrapping.
      if (checked_cnt_reg != {CNT_W{1'b1}})
        checked_cnt_reg <= checked_cnt_reg + 1'b1;
      if (mismatch && (err_cnt_reg != {CNT_W{1'b1}}))
        err_cnt_reg <= err_cnt_reg + 1'b1;
      if (mismatch && !first_err_valid_reg) begin
        first_err_valid_reg <= 1'b1;
        first_err_vec_reg   <= {cmp_vec, sum, co};
      end
      cov_map_reg  <= cov_map_next;
      cov_full_reg <= (cov_map_next == 8'hFF);
      case (state_reg)
        ST_IDLE:    state_reg <= mismatch ? ST_FAILED : ST_PASSING;
        ST_PASSING: if (mismatch) state_reg <= ST_FAILED;
        default:    state_reg <= ST_FAILED;
      endcase
    end
  end

  assign checked_cnt     = checked_cnt_reg;
  assign err_cnt         = err_cnt_reg;
  assign first_err_valid = first_err_valid_reg;
  assign first_err_vec   = first_err_vec_reg;
  assign cov_map         = cov_map_reg;
  assign cov_full        = cov_full_reg;
  assign status          = state_reg;

endmodule
